// File: rtl/control_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, opcodes,
// register codes, datapath select encodings, the control word and dispatch helpers.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_ALU = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB       = 4'd4,
        S_MEM_WR   = 4'd5,
        S_BRANCH   = 4'd6,
        S_JUMP     = 4'd7,
        S_SP_DEC   = 4'd8,
        S_IO       = 4'd9,
        S_NOP      = 4'd10,
        S_HALT     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LI   = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BR   = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_JAL  = 4'hA;
    localparam logic [3:0] OP_JR   = 4'hB;
    localparam logic [3:0] OP_PUSH = 4'hC;
    localparam logic [3:0] OP_POP  = 4'hD;
    localparam logic [3:0] OP_IO   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] DST_MARY    = 2'd0;
    localparam logic [1:0] DST_SHELLEY = 2'd1;
    localparam logic [1:0] DST_COMP    = 2'd2;
    localparam logic [1:0] DST_RA      = 2'd3;

    localparam logic [1:0] FN_IN  = 2'd0;
    localparam logic [1:0] FN_OUT = 2'd1;

    localparam logic [1:0] MSRC_PC     = 2'd0;
    localparam logic [1:0] MSRC_LS_IMM = 2'd1;
    localparam logic [1:0] MSRC_SP     = 2'd2;

    localparam logic [2:0] PCSRC_HOLD     = 3'd0;
    localparam logic [2:0] PCSRC_PLUS2    = 3'd1;
    localparam logic [2:0] PCSRC_BR_COND  = 3'd2;
    localparam logic [2:0] PCSRC_J_IMM    = 3'd3;
    localparam logic [2:0] PCSRC_RA       = 3'd4;
    localparam logic [2:0] PCSRC_TRAP_VEC = 3'd5;

    localparam logic [1:0] SPSRC_HOLD = 2'd0;
    localparam logic [1:0] SPSRC_DEC  = 2'd1;
    localparam logic [1:0] SPSRC_INC  = 2'd2;

    // Register write-data source for mary/shelley.
    localparam logic [1:0] RSRC_ALU = 2'd0;
    localparam logic [1:0] RSRC_MEM = 2'd1;
    localparam logic [1:0] RSRC_IMM = 2'd2;
    localparam logic [1:0] RSRC_IO  = 2'd3;

    localparam logic RA_SRC_ALU = 1'b0;
    localparam logic RA_SRC_PC  = 1'b1;

    localparam logic SRCA_PC  = 1'b0;
    localparam logic SRCA_DST = 1'b1;

    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_IMM = 2'd1;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;

    typedef struct packed {
        logic       mem_write;
        logic       pc_write;
        logic       sp_write;
        logic       inst_write;
        logic       mary_write;
        logic       shelley_write;
        logic       comp_write;
        logic       ra_write;
        logic [1:0] mem_src;
        logic [2:0] mem_dst;
        logic [2:0] pc_src;
        logic [1:0] sp_src;
        logic [1:0] mary_src;
        logic [1:0] shelley_src;
        logic       ra_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [3:0] alu_op;
        logic       halted;
    } ctrl_t;

    function automatic logic [3:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADDI: alu_op_of = ALU_ADD;
            OP_SUB:          alu_op_of = ALU_SUB;
            OP_AND:          alu_op_of = ALU_AND;
            OP_OR:           alu_op_of = ALU_OR;
            default:         alu_op_of = ALU_NONE;
        endcase
    endfunction

    // Only mary and shelley have a write-source mux; comp and ra take ALU data only.
    function automatic logic muxed_dst(input logic [1:0] dst);
        muxed_dst = (dst == DST_MARY) || (dst == DST_SHELLEY);
    endfunction

    // DECODE-state branch; illegal dst/funct combinations fall to S_NOP.
    function automatic state_t dispatch(input logic [3:0] op,
                                        input logic [1:0] dst,
                                        input logic [1:0] funct);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                dispatch = S_EXEC_ALU;
            OP_LI:   dispatch = muxed_dst(dst) ? S_EXEC_ALU : S_NOP;
            OP_LW:   dispatch = muxed_dst(dst) ? S_MEM_RD : S_NOP;
            OP_SW:   dispatch = S_MEM_WR;
            OP_BR:   dispatch = S_BRANCH;
            OP_J,
            OP_JAL:  dispatch = S_JUMP;
            OP_JR:   dispatch = (funct == 2'd0) ? S_JUMP : S_NOP;
            OP_PUSH: dispatch = S_SP_DEC;
            OP_POP:  dispatch = muxed_dst(dst) ? S_MEM_RD : S_NOP;
            OP_IO: begin
                if (funct == FN_IN)
                    dispatch = muxed_dst(dst) ? S_IO : S_NOP;
                else if (funct == FN_OUT)
                    dispatch = S_IO;
                else
                    dispatch = S_NOP;
            end
            default: dispatch = S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
// Carries instruction/overflow into the FSM and all strobes, selects and status out.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      instruction;
    logic             overflow;
    logic             MemWrite;
    logic             PCWrite;
    logic             SPWrite;
    logic             InstWrite;
    logic             mary_write;
    logic             shelley_write;
    logic             comp_write;
    logic             ra_write;
    logic [1:0]       MemSrc;
    logic [2:0]       MemDst;
    logic [2:0]       PCSrc;
    logic [1:0]       SPSrc;
    logic [1:0]       mary_src;
    logic [1:0]       shelley_src;
    logic             ra_src;
    logic             SrcA;
    logic [1:0]       SrcB;
    logic [3:0]       AluOp;
    logic             halted;
    logic [3:0]       state_out;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  instruction, overflow,
        output MemWrite, PCWrite, SPWrite, InstWrite,
        output mary_write, shelley_write, comp_write, ra_write,
        output MemSrc, MemDst, PCSrc, SPSrc, mary_src, shelley_src,
        output ra_src, SrcA, SrcB, AluOp, halted, state_out, retired_count
    );

    modport slave (
        output instruction, overflow,
        input  MemWrite, PCWrite, SPWrite, InstWrite,
        input  mary_write, shelley_write, comp_write, ra_write,
        input  MemSrc, MemDst, PCSrc, SPSrc, mary_src, shelley_src,
        input  ra_src, SrcA, SrcB, AluOp, halted, state_out, retired_count
    );
endinterface

// File: rtl/control_decode.sv
// Pure combinational decoder: FSM state + instruction fields -> control word.
// Ports: state, opcode, dst, funct, overflow (used only with OVERFLOW_TRAP_EN) in; ctrl out.
module control_decode
    import control_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic [1:0] dst,
    input  logic [1:0] funct,
    input  logic       overflow,
    output ctrl_t      ctrl
);

    logic       reg_wr;
    logic [1:0] reg_src;

`ifndef OVERFLOW_TRAP_EN
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

    always_comb begin
        ctrl    = '0;
        reg_wr  = 1'b0;
        reg_src = RSRC_ALU;
        unique case (state)
            S_FETCH: begin
                ctrl.inst_write = 1'b1;
                ctrl.mem_src    = MSRC_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PCSRC_PLUS2;
            end
            S_EXEC_ALU: begin
`ifdef OVERFLOW_TRAP_EN
                reg_wr = !overflow;
`else
                reg_wr = 1'b1;
`endif
                if (opcode == OP_LI) begin
                    reg_src = RSRC_IMM;
                end else begin
                    ctrl.alu_op = alu_op_of(opcode);
                    ctrl.src_a  = SRCA_DST;
                    ctrl.src_b  = (opcode == OP_ADDI) ? SRCB_IMM : SRCB_REG;
                end
            end
            S_MEM_RD: begin
                ctrl.mem_src = (opcode == OP_POP) ? MSRC_SP : MSRC_LS_IMM;
            end
            S_WB: begin
                reg_wr  = 1'b1;
                reg_src = RSRC_MEM;
                // POP bumps SP in the same cycle as its writeback.
                if (opcode == OP_POP) begin
                    ctrl.sp_write = 1'b1;
                    ctrl.sp_src   = SPSRC_INC;
                end
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.mem_src   = (opcode == OP_PUSH) ? MSRC_SP : MSRC_LS_IMM;
                ctrl.mem_dst   = {1'b0, dst};
            end
            S_BRANCH: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_BR_COND;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = (opcode == OP_JR) ? PCSRC_RA : PCSRC_J_IMM;
                if (opcode == OP_JAL) begin
                    ctrl.ra_write = 1'b1;
                    ctrl.ra_src   = RA_SRC_PC;
                end
            end
            S_SP_DEC: begin
                ctrl.sp_write = 1'b1;
                ctrl.sp_src   = SPSRC_DEC;
            end
            S_IO: begin
                // OUT presents dst on the store-data path; IN writes dst.
                if (funct == FN_IN) begin
                    reg_wr  = 1'b1;
                    reg_src = RSRC_IO;
                end else if (funct == FN_OUT) begin
                    ctrl.mem_dst = {1'b0, dst};
                end
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
`ifdef OVERFLOW_TRAP_EN
            S_TRAP: begin
                ctrl.ra_write = 1'b1;
                ctrl.ra_src   = RA_SRC_PC;
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_TRAP_VEC;
            end
`endif
            default: ;
        endcase

        ctrl.mary_write    = reg_wr && (dst == DST_MARY);
        ctrl.shelley_write = reg_wr && (dst == DST_SHELLEY);
        ctrl.comp_write    = reg_wr && (dst == DST_COMP);
        ctrl.ra_write      = ctrl.ra_write | (reg_wr && (dst == DST_RA));
        if (ctrl.mary_write)
            ctrl.mary_src = reg_src;
        if (ctrl.shelley_write)
            ctrl.shelley_src = reg_src;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: holds the state register and retired-instruction counter.
// Ports: clock, reset (async, active-high), bus (master modport). OVERFLOW_TRAP_EN adds TRAP.
module multicycle_control
    import control_pkg::*;
#(
    parameter int          CNT_W       = 16,
    parameter logic [15:0] TRAP_VECTOR = 16'h0010
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t           state;
    logic [CNT_W-1:0] retired;
    ctrl_t            ctrl;
    logic [3:0]       opcode;
    logic [1:0]       dst;
    logic [1:0]       funct;

    // The trap target is applied by the datapath; the immediate is datapath-only.
    logic [15:0] unused_trap_vec;
    logic [7:0]  unused_imm;
    assign unused_trap_vec = TRAP_VECTOR;
    assign unused_imm      = bus.instruction[9:2];

    assign opcode = bus.instruction[15:12];
    assign dst    = bus.instruction[11:10];
    assign funct  = bus.instruction[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            unique case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= dispatch(opcode, dst, funct);
                S_MEM_RD: state <= S_WB;
                S_SP_DEC: state <= S_MEM_WR;
                S_HALT:   state <= S_HALT;
`ifdef OVERFLOW_TRAP_EN
                S_EXEC_ALU: begin
                    if (bus.overflow) begin
                        state <= S_TRAP;
                    end else begin
                        state   <= S_FETCH;
                        retired <= retired + 1'b1;
                    end
                end
`endif
                // Every remaining state completes an instruction.
                default: begin
                    state   <= S_FETCH;
                    retired <= retired + 1'b1;
                end
            endcase
        end
    end

    control_decode u_decode (
        .state    (state),
        .opcode   (opcode),
        .dst      (dst),
        .funct    (funct),
        .overflow (bus.overflow),
        .ctrl     (ctrl)
    );

    assign bus.MemWrite      = ctrl.mem_write;
    assign bus.PCWrite       = ctrl.pc_write;
    assign bus.SPWrite       = ctrl.sp_write;
    assign bus.InstWrite     = ctrl.inst_write;
    assign bus.mary_write    = ctrl.mary_write;
    assign bus.shelley_write = ctrl.shelley_write;
    assign bus.comp_write    = ctrl.comp_write;
    assign bus.ra_write      = ctrl.ra_write;
    assign bus.MemSrc        = ctrl.mem_src;
    assign bus.MemDst        = ctrl.mem_dst;
    assign bus.PCSrc         = ctrl.pc_src;
    assign bus.SPSrc         = ctrl.sp_src;
    assign bus.mary_src      = ctrl.mary_src;
    assign bus.shelley_src   = ctrl.shelley_src;
    assign bus.ra_src        = ctrl.ra_src;
    assign bus.SrcA          = ctrl.src_a;
    assign bus.SrcB          = ctrl.src_b;
    assign bus.AluOp         = ctrl.alu_op;
    assign bus.halted        = ctrl.halted;
    assign bus.state_out     = state;
    assign bus.retired_count = retired;

endmodule
